// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults, LMAX and duty scale derivation for the RGB PWM controller.
package pwm_pkg;

    localparam int N_CH_DEF    = 3;
    localparam int LVL_W_DEF   = 3;
    localparam int PWM_W_DEF   = 8;
    localparam int PRESC_DEF   = 1;
    localparam int RST_LVL_DEF = 0;

    function automatic int lmax(input int lvl_w);
        return (1 << lvl_w) - 1;
    endfunction

    // Largest K such that LMAX*K still fits in one PWM period.
    function automatic int duty_k(input int pwm_w, input int lvl_w);
        return ((1 << pwm_w) - 1) / lmax(lvl_w);
    endfunction

    localparam int LMAX_DEF = lmax(LVL_W_DEF);

endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: per-channel shadow level/duty, period compare and registered output.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int LVL_W = LVL_W_DEF,
    parameter int PWM_W = PWM_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [LVL_W-1:0] eff_i,
    input  logic [PWM_W-1:0] cnt_i,
    output logic             pwm_o
);

    localparam logic [PWM_W-1:0] K = PWM_W'(duty_k(PWM_W, LVL_W));

    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

    // Full level forces a constant high; level 0 gives duty 0 and never compares true.
    always_comb begin
        lvl_d  = load_i ? eff_i : lvl_q;
        duty_d = load_i ? PWM_W'(eff_i) * K : duty_q;
        pwm_d  = (&lvl_q) | (cnt_i < duty_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            lvl_q  <= lvl_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_multi_ctrl.sv
// rgb_pwm_multi_ctrl: stepped multi-channel PWM brightness controller.
// Define PWM_FADE_EN to add the shared breathing (fade) level.
module rgb_pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int LVL_W   = LVL_W_DEF,
    parameter int PWM_W   = PWM_W_DEF,
    parameter int PRESC   = PRESC_DEF,
    parameter int RST_LVL = RST_LVL_DEF
) (
    input  logic                  main_Clk50Mhz,
    input  logic                  main_rst,
    input  logic                  step_up,
    input  logic                  step_down,
    input  logic [N_CH-1:0]       ch_sel,
    input  logic                  fade_mode,
    output logic [N_CH-1:0]       pwm_out,
    output logic [N_CH*LVL_W-1:0] level_flat,
    output logic                  sat_flag
);

    localparam int               PSW       = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PSW-1:0]   PRESC_TOP = PSW'(PRESC - 1);
    localparam logic [LVL_W-1:0] LVL_RST   = LVL_W'(RST_LVL);

    logic [PSW-1:0]               presc_q, presc_d;
    logic [PWM_W-1:0]             cnt_q, cnt_d;
    logic [N_CH-1:0][LVL_W-1:0]   lvl_q, lvl_d, eff;
    logic                         sat_q, sat_d;
    logic                         tick, wrap, step;

    always_comb begin
        tick    = presc_q == PRESC_TOP;
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
        wrap    = tick && (&cnt_q);
        step    = (step_up ^ step_down) && (|ch_sel);
        lvl_d   = lvl_q;
        sat_d   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (step && ch_sel[i]) begin
                if (step_up ? (&lvl_q[i]) : (lvl_q[i] == '0))
                    sat_d = 1'b1;
                else
                    lvl_d[i] = step_up ? lvl_q[i] + 1'b1 : lvl_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge main_Clk50Mhz) begin
        if (main_rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            lvl_q   <= {N_CH{LVL_RST}};
            sat_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            sat_q   <= sat_d;
        end
    end

`ifdef PWM_FADE_EN
    logic [LVL_W-1:0] fade_q, fade_d;
    logic             up_q, up_d;

    // Triangle 0..LMAX..0, advanced once per completed period.
    always_comb begin
        fade_d = fade_q;
        up_d   = up_q;
        if (!fade_mode) begin
            fade_d = '0;
            up_d   = 1'b1;
        end else if (wrap) begin
            if (up_q) begin
                fade_d = (&fade_q) ? fade_q - 1'b1 : fade_q + 1'b1;
                up_d   = ~(&fade_q);
            end else begin
                fade_d = (fade_q == '0) ? fade_q + 1'b1 : fade_q - 1'b1;
                up_d   = fade_q == '0;
            end
        end
        for (int i = 0; i < N_CH; i++)
            eff[i] = (!fade_mode || lvl_q[i] < fade_q) ? lvl_q[i] : fade_q;
    end

    always_ff @(posedge main_Clk50Mhz) begin
        if (main_rst) begin
            fade_q <= '0;
            up_q   <= 1'b1;
        end else begin
            fade_q <= fade_d;
            up_q   <= up_d;
        end
    end
`else
    logic unused_fade;
    assign unused_fade = fade_mode;
    assign eff         = lvl_q;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pwm_chan #(
            .LVL_W (LVL_W),
            .PWM_W (PWM_W)
        ) u_ch (
            .clk_i  (main_Clk50Mhz),
            .rst_i  (main_rst),
            .load_i (wrap),
            .eff_i  (eff[c]),
            .cnt_i  (cnt_q),
            .pwm_o  (pwm_out[c])
        );
    end

    assign level_flat = lvl_q;
    assign sat_flag   = sat_q;

endmodule

// File: doc/rgb_pwm_multi_ctrl.md
RGB_PWM_MULTI_CTRL -- requirements
Module: rgb_pwm_multi_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of PWM channels.
REQ-002 SHALL have parameter LVL_W, default 3: brightness level width; levels run 0..LMAX, where LMAX = 2^LVL_W-1.
REQ-003 SHALL have parameter PWM_W, default 8: PWM counter width; the period is 2^PWM_W ticks.
REQ-004 SHALL have parameter PRESC, default 1: number of clocks per PWM tick (PRESC >= 1).
REQ-005 SHALL have parameter RST_LVL, default 0: per-channel level loaded at reset.
REQ-006 SHALL have port main_Clk50Mhz, input, width 1: the single clock.
REQ-007 SHALL have port main_rst, input, width 1: reset, synchronous and active-high.
REQ-008 SHALL have port step_up, input, width 1: one-cycle pulse from an already-debounced button.
REQ-009 SHALL have port step_down, input, width 1: one-cycle pulse from an already-debounced button.
REQ-010 SHALL have port ch_sel, input, width N_CH: bit i set means channel i is targeted by steps.
REQ-011 SHALL have port fade_mode, input, width 1: level-sensitive breathing-mode request.
REQ-012 SHALL have port pwm_out, output, width N_CH: registered PWM outputs.
REQ-013 SHALL have port level_flat, output, width N_CH*LVL_W: current level of each channel; channel i occupies bits [i*LVL_W +: LVL_W], for the display block.
REQ-014 SHALL have port sat_flag, output, width 1: one-cycle pulse when a step is refused at either bound.

Function
REQ-015 SHALL process a step on each clock with step_up XOR step_down: every channel with its ch_sel bit set goes to level+1 (up) or level-1 (down).
REQ-016 SHALL saturate levels: an up step at LMAX and a down step at 0 leave the level unchanged.
REQ-017 SHALL assert sat_flag in the cycle after a step in which at least one selected channel was at the bound.
REQ-018 SHALL ignore a clock with step_up and step_down both high; no level change and no sat_flag.
REQ-019 SHALL ignore steps when ch_sel is all zeros; no level change and no sat_flag.
REQ-020 SHALL update level_flat one clock after the accepted step.
REQ-021 SHALL generate tick as a one-cycle strobe every PRESC clocks from a prescaler counter.
REQ-022 SHALL use a shared period counter cnt (PWM_W bits) that increments on each tick and wraps from 2^PWM_W-1 to 0.
REQ-023 SHALL compute effective duty per channel as eff*K, where K = floor((2^PWM_W-1)/LMAX).
REQ-024 SHALL latch duty into a shadow register only on the tick where cnt wraps to 0, so a level change never alters the period in progress.
REQ-025 SHALL drive pwm_out[i] = 1 when the shadow level equals LMAX (100% duty).
REQ-026 SHALL otherwise drive pwm_out[i] = (cnt < shadow duty).
REQ-027 SHALL register pwm_out, giving one clock of latency from cnt to pin.
REQ-028 SHALL drive level 0 as a constant 0 output.

Reset
REQ-029 SHALL, while main_rst is high at a clock edge, reset: all levels to RST_LVL; shadow duties to 0; cnt to 0; the prescaler to 0; pwm_out to 0; sat_flag to 0; fade state to 0 with direction up.
REQ-030 SHALL take reset asserted mid-period effect at that edge; the first PWM period after release begins at cnt = 0.
REQ-031 SHALL give reset priority over steps and ticks in the same cycle.

Configuration
REQ-032 SHALL, with PWM_FADE_EN defined, implement a shared fade level (LVL_W bits).
REQ-033 SHALL step the fade level once per completed PWM period while fade_mode = 1, as a triangle 0->LMAX->0 that reverses at each bound.
REQ-034 SHALL, with PWM_FADE_EN defined, use eff = min(level, fade level) for each channel.
REQ-035 SHALL, when fade_mode drops to 0, reset the fade level to 0 with direction up, and use eff = level.
REQ-036 SHALL, without PWM_FADE_EN, keep the fade_mode port but ignore it, use eff = level, and synthesise no fade logic.

Structure
REQ-037 SHALL place the default parameter values, LMAX and the K derivation function in the shared package pwm_pkg.
REQ-038 SHALL instantiate N_CH copies of the sub-module pwm_chan: shadow register, compare and output flop.
REQ-039 SHALL hold the level registers, prescaler, cnt and fade logic in the top module.

Verification (defaults, PRESC=1)
REQ-040 SHALL check: from reset, ch_sel=3'b001, 7 step_up pulses -> level R = 7; R output held high after the next period boundary; G and B stay 0.
REQ-041 SHALL check: at R = 7, an 8th step_up -> level stays 7 and sat_flag pulses for 1 cycle; then at R = 0, a step_down -> sat_flag pulses.
REQ-042 SHALL check: R = 1 -> pwm_out[0] high for exactly 36 of every 256 clocks; R = 4 -> high for 144 clocks.
REQ-043 SHALL check: a step at cnt = 100 -> the current period keeps the old duty and the new duty starts at the next cnt = 0.
REQ-044 SHALL check: step_up and step_down high in the same cycle, ch_sel=3'b111 -> no level change; ch_sel = 0 with a step -> no change.
REQ-045 SHALL check: main_rst asserted at cnt = 50 with all levels at 5 -> the next cycle has all outputs 0 and levels at RST_LVL; with PWM_FADE_EN and level 7, fade_mode = 1 -> duty ramps 0..7..0 with one step per period.
